pipe_skid_reg: RTL



---
 rtl/pipe_pkg.sv | 31 +++
 rtl/register.sv | 38 +++
 rtl/pipe_skid_reg.sv | 115 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and constants for the skid-buffered pipe stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } skid_state_t;

  localparam int SKID_DEPTH = 2;
  localparam int COUNT_W    = $clog2(SKID_DEPTH + 1);

  // Number of payloads held in each state; the unused encoding reports zero.
  function automatic logic [COUNT_W-1:0] state_count(input skid_state_t s);
    logic [COUNT_W-1:0] n;
    n = '0;
    case (s)
      BUSY:    n = COUNT_W'(1);
      FULL:    n = COUNT_W'(2);
      default: n = '0;
    endcase
    return n;
  endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/register.sv
`default_nettype none
// ============================================================================
//  Module      : register
//  Description : Write-enabled storage register, cleared by synchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             writeEnable,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (writeEnable) begin
      data_d = dataIn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign dataOut = data_q;

endmodule : register
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_reg
//  Description : Pipeline-stage register with valid/ready handshake and a
//                one-entry skid buffer; in_ready depends on state only.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  skid_state_t      state_q;
  skid_state_t      state_d;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_we;
  logic             w_skid_we;
  logic [WIDTH-1:0] w_main_din;
  logic [WIDTH-1:0] w_skid_dout;

  // All outputs decode registered state only.
  assign in_ready  = (state_q == EMPTY) || (state_q == BUSY);
  assign out_valid = (state_q == BUSY)  || (state_q == FULL);
  assign count     = state_count(state_q);

  assign w_in_fire  = in_valid  & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    w_main_we  = 1'b0;
    w_skid_we  = 1'b0;
    w_main_din = in_data;

    case (state_q)
      EMPTY: begin
        if (w_in_fire) begin
          state_d   = BUSY;
          w_main_we = 1'b1;
        end
      end
      BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_main_we = 1'b1;
        end else if (w_in_fire) begin
          state_d   = FULL;
          w_skid_we = 1'b1;
        end else if (w_out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        w_main_din = w_skid_dout;
        if (w_out_fire) begin
          state_d   = BUSY;
          w_main_we = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // Flush drops everything held; data registers keep stale contents.
    if (flush) begin
      state_d   = EMPTY;
      w_main_we = 1'b0;
      w_skid_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  register #(
    .WIDTH (WIDTH)
  ) u_main_reg (
    .clk         (clk),
    .reset       (reset),
    .writeEnable (w_main_we),
    .dataIn      (w_main_din),
    .dataOut     (out_data)
  );

  register #(
    .WIDTH (WIDTH)
  ) u_skid_reg (
    .clk         (clk),
    .reset       (reset),
    .writeEnable (w_skid_we),
    .dataIn      (in_data),
    .dataOut     (w_skid_dout)
  );

endmodule : pipe_skid_reg
`default_nettype wire
